// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//
// Multi-cycle control unit for the accumulator microprocessor. Each instruction runs for three
// cycles: FETCH, DECODE and EXECUTE. At the edge that ends FETCH the instruction register
// captures the ROM word. During EXECUTE the unit drives one cycle of enables to the PC,
// the A/B registers, the ALU and the output register. The carry and zero flags are captured
// at the edge that leaves EXECUTE of an ADD or SUB. They are then used by JC and JZ.
// HLT parks the unit in HALT until reset.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   instr      ROM word at the current PC: {opcode[3:0], operand[BIT_WIDTH-1:0]}
//   alu_carry  ALU carry/borrow-out for the current A,B
//   alu_zero   ALU result == 0
//   pc_inc     PC += 1 at the next edge
//   pc_load    PC <= imm at the next edge
//   imm        operand field of the instruction register
//   a_load     accumulator load enable
//   a_src      accumulator source: 0 imm, 1 ALU result, 2 B
//   b_load     B register load enable
//   b_src      B source: 0 imm, 1 A
//   alu_sub    ALU op: 0 add, 1 subtract
//   out_load   output register <= A
//   halted     high in HALT
//   state      current state, for debug

module cpu_sequencer #(
  parameter int unsigned BIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIT_WIDTH+3:0]   instr,
  input  logic                   alu_carry,
  input  logic                   alu_zero,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic [BIT_WIDTH-1:0]   imm,
  output logic                   a_load,
  output logic [1:0]             a_src,
  output logic                   b_load,
  output logic                   b_src,
  output logic                   alu_sub,
  output logic                   out_load,
  output logic                   halted,
  output logic [2:0]             state
);

  // Opcode encodings
  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpLdb = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpMab = 4'h5;
  localparam logic [3:0] OpMba = 4'h6;
  localparam logic [3:0] OpOut = 4'h7;
  localparam logic [3:0] OpJmp = 4'h8;
  localparam logic [3:0] OpJc  = 4'h9;
  localparam logic [3:0] OpJz  = 4'hA;
  localparam logic [3:0] OpHlt = 4'hF;

  // Accumulator source select
  localparam logic [1:0] ASrcImm = 2'd0;
  localparam logic [1:0] ASrcAlu = 2'd1;
  localparam logic [1:0] ASrcB   = 2'd2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StHalt    = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [BIT_WIDTH+3:0]   ir_q, ir_d;
  logic                   carry_q, carry_d;
  logic                   zero_q, zero_d;

  logic [3:0]             opcode;
  logic                   in_execute;

  assign opcode     = ir_q[BIT_WIDTH+3:BIT_WIDTH];
  assign in_execute = (state_q == StExecute);

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        ir_d    = instr;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StExecute;
      end
      StExecute: begin
        // Flags follow only arithmetic, so a conditional jump always sees the last ADD/SUB.
        if ((opcode == OpAdd) || (opcode == OpSub)) begin
          carry_d = alu_carry;
          zero_d  = alu_zero;
        end
        state_d = (opcode == OpHlt) ? StHalt : StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ir_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output decode
  // Every enable is derived from the registered state. An asynchronous reset therefore clears
  // all enables at once, with no clock edge needed.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    a_load   = 1'b0;
    a_src    = ASrcImm;
    b_load   = 1'b0;
    b_src    = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;

    if (in_execute) begin
      // Default PC advance. Taken jumps and HLT override it, so inc and load never coexist.
      pc_inc = 1'b1;
      unique case (opcode)
        OpNop: ;
        OpLda: begin
          a_load = 1'b1;
          a_src  = ASrcImm;
        end
        OpLdb: begin
          b_load = 1'b1;
          b_src  = 1'b0;
        end
        OpAdd: begin
          a_load  = 1'b1;
          a_src   = ASrcAlu;
          alu_sub = 1'b0;
        end
        OpSub: begin
          a_load  = 1'b1;
          a_src   = ASrcAlu;
          alu_sub = 1'b1;
        end
        OpMab: begin
          b_load = 1'b1;
          b_src  = 1'b1;
        end
        OpMba: begin
          a_load = 1'b1;
          a_src  = ASrcB;
        end
        OpOut: begin
          out_load = 1'b1;
        end
        OpJmp: begin
          pc_inc  = 1'b0;
          pc_load = 1'b1;
        end
        OpJc: begin
          pc_inc  = ~carry_q;
          pc_load = carry_q;
        end
        OpJz: begin
          pc_inc  = ~zero_q;
          pc_load = zero_q;
        end
        OpHlt: begin
          pc_inc = 1'b0;
        end
        // Opcodes B-E behave as NOP.
        default: ;
      endcase
    end
  end

  assign imm    = ir_q[BIT_WIDTH-1:0];
  assign halted = (state_q == StHalt);
  assign state  = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst;
  logic [W+3:0]   instr;
  logic           alu_carry;
  logic           alu_zero;
  logic           pc_inc;
  logic           pc_load;
  logic [W-1:0]   imm;
  logic           a_load;
  logic [1:0]     a_src;
  logic           b_load;
  logic           b_src;
  logic           alu_sub;
  logic           out_load;
  logic           halted;
  logic [2:0]     state;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_sequencer #(.BIT_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .imm       (imm),
    .a_load    (a_load),
    .a_src     (a_src),
    .b_load    (b_load),
    .b_src     (b_src),
    .alu_sub   (alu_sub),
    .out_load  (out_load),
    .halted    (halted),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable vector: {pc_inc, pc_load, a_load, a_src[1:0], b_load, b_src, alu_sub, out_load}
  function automatic logic [8:0] en(input logic pi, input logic pl, input logic al,
                                    input logic [1:0] as, input logic bl, input logic bs,
                                    input logic sb, input logic ol);
    return {pi, pl, al, as, bl, bs, sb, ol};
  endfunction

  function automatic logic [8:0] dut_en();
    return {pc_inc, pc_load, a_load, a_src, b_load, b_src, alu_sub, out_load};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH: present the word, then advance to EXECUTE and check its decode.
  task automatic exec(input string tag, input logic [W+3:0] ins, input logic c,
                      input logic z, input logic [8:0] exp_en);
    check({tag, "_fetch"}, {29'd0, state}, 32'd1);
    instr     = ins;
    alu_carry = c;
    alu_zero  = z;
    step();
    check({tag, "_decode_en"}, {23'd0, dut_en()}, 32'd0);
    step();
    check({tag, "_state"}, {29'd0, state}, 32'd3);
    check({tag, "_en"}, {23'd0, dut_en()}, {23'd0, exp_en});
    check({tag, "_imm"}, {28'd0, imm}, {28'd0, ins[W-1:0]});
    step();
  endtask

  initial begin
    rst       = 1'b0;
    instr     = '0;
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    #2;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_en", {23'd0, dut_en()}, 32'd0);
    check("rst_imm_halt", {27'd0, imm, halted}, 32'd0);
    #5 rst = 1'b1;
    step();

    exec("lda5", 8'h15, 1'b0, 1'b0, en(1, 0, 1, 2'd0, 0, 0, 0, 0));
    exec("out",  8'h70, 1'b0, 1'b0, en(1, 0, 0, 2'd0, 0, 0, 0, 1));
    exec("lda9", 8'h19, 1'b0, 1'b0, en(1, 0, 1, 2'd0, 0, 0, 0, 0));
    exec("ldb8", 8'h28, 1'b0, 1'b0, en(1, 0, 0, 2'd0, 1, 0, 0, 0));
    exec("add",  8'h30, 1'b1, 1'b0, en(1, 0, 1, 2'd1, 0, 0, 0, 0));
    exec("jc_t", 8'h9C, 1'b0, 1'b1, en(0, 1, 0, 2'd0, 0, 0, 0, 0));
    exec("jz_n", 8'hA3, 1'b0, 1'b1, en(1, 0, 0, 2'd0, 0, 0, 0, 0));
    exec("opb",  8'hB6, 1'b1, 1'b1, en(1, 0, 0, 2'd0, 0, 0, 0, 0));
    exec("mab",  8'h50, 1'b0, 1'b0, en(1, 0, 0, 2'd0, 1, 1, 0, 0));
    exec("mba",  8'h60, 1'b0, 1'b0, en(1, 0, 1, 2'd2, 0, 0, 0, 0));
    exec("jmp",  8'h87, 1'b0, 1'b0, en(0, 1, 0, 2'd0, 0, 0, 0, 0));
    exec("nop",  8'h0E, 1'b0, 1'b0, en(1, 0, 0, 2'd0, 0, 0, 0, 0));
    exec("lda4", 8'h14, 1'b0, 1'b0, en(1, 0, 1, 2'd0, 0, 0, 0, 0));
    exec("ldb4", 8'h24, 1'b0, 1'b0, en(1, 0, 0, 2'd0, 1, 0, 0, 0));
    exec("sub",  8'h40, 1'b0, 1'b1, en(1, 0, 1, 2'd1, 0, 0, 1, 0));
    // Non-arithmetic instruction with opposite ALU flags must not disturb the stored flags.
    exec("hold", 8'h11, 1'b1, 1'b0, en(1, 0, 1, 2'd0, 0, 0, 0, 0));
    exec("jz_t", 8'hA2, 1'b0, 1'b0, en(0, 1, 0, 2'd0, 0, 0, 0, 0));
    exec("jc_n", 8'h95, 1'b1, 1'b0, en(1, 0, 0, 2'd0, 0, 0, 0, 0));
    exec("add2", 8'h30, 1'b1, 1'b0, en(1, 0, 1, 2'd1, 0, 0, 0, 0));

    // Reset in the middle of an ADD execute: carry is 1 before this point.
    check("mid_fetch", {29'd0, state}, 32'd1);
    instr     = 8'h30;
    alu_carry = 1'b1;
    alu_zero  = 1'b1;
    step();
    step();
    check("mid_exec_en", {23'd0, dut_en()}, {23'd0, en(1, 0, 1, 2'd1, 0, 0, 0, 0)});
    #1 rst = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, state}, 32'd0);
    check("mid_rst_en", {23'd0, dut_en()}, 32'd0);
    check("mid_rst_imm", {28'd0, imm}, 32'd0);
    instr = 8'h95;
    #1 rst = 1'b1;
    step();
    check("rel_s1", {29'd0, state}, 32'd1);
    step();
    check("rel_s2", {29'd0, state}, 32'd2);
    step();
    check("rel_s3", {29'd0, state}, 32'd3);
    // Carry was cleared by the reset, so JC 5 falls through.
    check("rel_jc_en", {23'd0, dut_en()}, {23'd0, en(1, 0, 0, 2'd0, 0, 0, 0, 0)});
    step();

    exec("hlt", 8'hF9, 1'b1, 1'b1, en(0, 0, 0, 2'd0, 0, 0, 0, 0));
    for (int i = 0; i < 24; i++) begin
      instr = 8'h80 | 8'(i);
      check("halt_state", {29'd0, state}, 32'd4);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_en", {23'd0, dut_en()}, 32'd0);
      step();
    end
    check("halt_imm", {28'd0, imm}, 32'd9);
    #1 rst = 1'b0;
    #1;
    check("halt_rst_state", {29'd0, state}, 32'd0);
    check("halt_rst_flag", {31'd0, halted}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the BIT_WIDTH accumulator microprocessor. It fetches one instruction per pass from the combinational instruction ROM, holds it in an internal instruction register, and drives the PC, register-file, ALU and output-register enables for one execute cycle. It also keeps the carry and zero flags and handles conditional jumps and halt. It sits between the ROM/PC and the datapath inside `top`.

## Interface
- BIT_WIDTH, 4, datapath and operand width; the instruction word is 4 + BIT_WIDTH bits
- clk  in  1  clock, all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- instr  in  4+BIT_WIDTH  ROM data at the current PC; opcode is [BIT_WIDTH+3:BIT_WIDTH], operand is [BIT_WIDTH-1:0]
- alu_carry  in  1  ALU carry/borrow-out for the current A,B
- alu_zero  in  1  ALU result == 0
- pc_inc  out  1  PC += 1 at the next edge
- pc_load  out  1  PC <= imm at the next edge
- imm  out  BIT_WIDTH  operand field of the instruction register
- a_load  out  1  accumulator A load enable
- a_src  out  2  A source: 0 imm, 1 ALU result, 2 B
- b_load  out  1  register B load enable
- b_src  out  1  B source: 0 imm, 1 A
- alu_sub  out  1  ALU op: 0 add, 1 subtract
- out_load  out  1  output register <= A
- halted  out  1  high in HALT
- state  out  3  current state, for debug

## Operation
- Opcodes: 0 NOP, 1 LDA imm, 2 LDB imm, 3 ADD (A<=A+B), 4 SUB (A<=A-B), 5 MAB (B<=A), 6 MBA (A<=B), 7 OUT, 8 JMP imm, 9 JC imm, A JZ imm, F HLT. Opcodes B–E execute as NOP.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, HALT=4.
- Transitions:
  - IDLE -> FETCH
  - FETCH -> DECODE; IR <= instr at this edge
  - DECODE -> EXECUTE
  - EXECUTE -> FETCH, or -> HALT when the opcode is HLT
  - HALT -> HALT until reset
- All outputs are combinational decodes of the registered state, IR and flags. Every output is 0 outside EXECUTE, except `halted` (high in HALT) and `state`.
- EXECUTE outputs:
  - LDA: a_load=1, a_src=0
  - LDB: b_load=1, b_src=0
  - ADD: a_load=1, a_src=1, alu_sub=0
  - SUB: a_load=1, a_src=1, alu_sub=1
  - MAB: b_load=1, b_src=1
  - MBA: a_load=1, a_src=2
  - OUT: out_load=1
- PC control in EXECUTE:
  - pc_load=1 for JMP; for JC when carry_flag=1; for JZ when zero_flag=1
  - pc_inc=1 in every other EXECUTE, including NOP, illegal opcodes and not-taken jumps
  - HLT: neither pc_inc nor pc_load
- pc_inc and pc_load are never high together.
- Flags: carry_flag and zero_flag are internal registers, reset to 0. They load alu_carry and alu_zero at the edge leaving EXECUTE of ADD or SUB only; all other instructions hold them.
- `imm` shows IR[BIT_WIDTH-1:0] in every state.

## Timing
- Reset (rst low): state=IDLE; IR, carry_flag and zero_flag = 0. All outputs 0, including imm, halted and state. Reset takes effect immediately, without waiting for clk, from any state including mid-EXECUTE; no partial enable survives.
- First edge after rst rises: IDLE -> FETCH. The first instruction's EXECUTE is the 4th cycle after release.
- Each instruction takes exactly 3 cycles (FETCH, DECODE, EXECUTE). The PC changes at the edge ending EXECUTE, and the next FETCH samples the new PC.
- Arithmetic wraps modulo 2^BIT_WIDTH in the datapath. The sequencer only records the carry/borrow.
- PC wrap from 2^BIT_WIDTH-1 to 0 is the PC's own behaviour; the sequencer just asserts pc_inc.
- A jump whose condition flag is being updated in the same instruction is impossible by construction, since flags change only on ADD/SUB. A conditional jump always uses the flag value from the last ADD/SUB.

## Test plan
- Reset mid-EXECUTE: assert rst low during EXECUTE of ADD -> outputs 0 at once, state=0. Release rst -> state sequence 1,2,3 on the next three edges.
- Load and output: program LDA 5, OUT -> a_load=1, a_src=0, imm=5 in the 4th cycle after release. out_load=1 in the 7th cycle. pc_inc high in both EXECUTEs.
- ADD with carry, then JC taken: LDA 9, LDB 8, ADD, JC 0xC. The ALU drives alu_carry=1, alu_zero=0 during ADD -> JC EXECUTE has pc_load=1, pc_inc=0, imm=C.
- JZ not taken and illegal opcode: after the above, JZ 3 -> pc_inc=1, pc_load=0. Opcode B -> pc_inc=1, all other enables 0.
- SUB to zero: LDA 4, LDB 4, SUB with alu_zero=1 -> JZ 2 gives pc_load=1, imm=2. Also check alu_sub=1 during SUB.
- Halt: HLT -> EXECUTE with pc_inc=0, pc_load=0. Then state=4, halted=1, all enables 0 for 20+ cycles, until rst goes low.
